// File: rtl/team_06_delay_line_ctrl_pkg.sv
// Shared types and effect-select codes for the team_06 audio delay line.
package team_06_audio_pkg;

  typedef enum logic [1:0] {IDLE, RD_REQ, MIX, WR_REQ} dl_state_t;

  localparam logic [2:0] SEL_BYPASS   = 3'b000;
  localparam logic [2:0] SEL_TREMELO  = 3'b001;
  localparam logic [2:0] SEL_ECHO     = 3'b010;
  localparam logic [2:0] SEL_SOFTCLIP = 3'b011;
  localparam logic [2:0] SEL_REVERB   = 3'b100;

  function automatic logic is_active_sel(input logic [2:0] sel);
    return (sel == SEL_ECHO) || (sel == SEL_REVERB);
  endfunction

endpackage

// File: rtl/team_06_delay_line_ctrl_mem.sv
// Request/ack handshake toward the SRAM R/W module: holds the request fields
// steady until ack or timeout and reports completion as single-cycle pulses.
module team_06_mem_handshake #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              timed_out
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_reg;

  // An ack outside an open request is meaningless and must not complete anything.
  assign done      = mem_req & mem_ack;
  assign timed_out = mem_req & ~mem_ack & (wait_cnt_reg == CNT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wait_cnt_reg <= '0;
    end else if (start) begin
      mem_req      <= 1'b1;
      mem_we       <= we;
      mem_addr     <= addr;
      mem_wdata    <= wdata;
      wait_cnt_reg <= '0;
    end else if (done || timed_out) begin
      mem_req <= 1'b0;
    end else if (mem_req) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/team_06_delay_line_ctrl.sv
// Delay-line sequencer: per accepted sample, read the delayed sample (unless the
// line is still warming up), hand it to the effect datapath, then write the mix.
module team_06_delay_line_ctrl
  import team_06_audio_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int ECHO_DLY    = 4000,
  parameter int REVERB_DLY  = 1200,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        sel,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] past_sample,
  output logic              past_valid,
  input  logic [DATA_W-1:0] mix_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  dl_state_t         state_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] fill_cnt_reg;
  logic [2:0]        prev_mode_reg;

  logic              mode_active;
  logic              accept;
  logic              read_needed;
  logic [ADDR_W-1:0] dly;
  logic [ADDR_W-1:0] fill_eff;
  logic              hs_start;
  logic              hs_we;
  logic [ADDR_W-1:0] hs_addr;
  logic [DATA_W-1:0] hs_wdata;
  logic              hs_done;
  logic              hs_timed_out;

  assign mode_active = is_active_sel(sel);
  assign dly         = (sel == SEL_ECHO) ? ADDR_W'(ECHO_DLY) : ADDR_W'(REVERB_DLY);
  // A mode change means the stored history belongs to another effect.
  assign fill_eff    = (sel == prev_mode_reg) ? fill_cnt_reg : '0;
  assign read_needed = (fill_eff >= dly);
  assign accept      = (state_reg == IDLE) && sample_valid && mode_active;
  assign busy        = (state_reg != IDLE);

  always_comb begin
    hs_start = 1'b0;
    hs_we    = 1'b0;
    hs_addr  = wr_ptr_reg;
    hs_wdata = mix_in;
    if (accept && read_needed) begin
      hs_start = 1'b1;
      hs_addr  = wr_ptr_reg - dly;
    end else if (state_reg == MIX) begin
      hs_start = 1'b1;
      hs_we    = 1'b1;
    end
  end

  team_06_mem_handshake #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_hs (
    .clk       (clk),
    .rst       (rst),
    .start     (hs_start),
    .we        (hs_we),
    .addr      (hs_addr),
    .wdata     (hs_wdata),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (hs_done),
    .timed_out (hs_timed_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      fill_cnt_reg  <= '0;
      prev_mode_reg <= SEL_BYPASS;
      past_sample   <= '0;
      past_valid    <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      past_valid <= 1'b0;
      if (sample_valid && (state_reg != IDLE)) overrun <= 1'b1;
      if (hs_timed_out) timeout_err <= 1'b1;
      if (!mode_active) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (!mode_active) begin
            fill_cnt_reg <= '0;
          end else if (sample_valid) begin
            prev_mode_reg <= sel;
            fill_cnt_reg  <= fill_eff;
            if (read_needed) begin
              state_reg <= RD_REQ;
            end else begin
              past_sample <= '0;
              past_valid  <= 1'b1;
              state_reg   <= MIX;
            end
          end
        end
        RD_REQ: begin
          if (hs_done) begin
            past_sample <= mem_rdata;
            past_valid  <= 1'b1;
            state_reg   <= MIX;
          end else if (hs_timed_out) begin
            past_sample <= '0;
            past_valid  <= 1'b1;
            state_reg   <= MIX;
          end
        end
        MIX: state_reg <= WR_REQ;
        WR_REQ: begin
          if (hs_done) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fill_cnt_reg != '1) fill_cnt_reg <= fill_cnt_reg + 1'b1;
            state_reg <= IDLE;
          end else if (hs_timed_out) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_06_delay_line_ctrl.sv
// Randomized bench for the delay-line sequencer against a transaction-level model.
module tb_team_06_delay_line_ctrl;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int ECHO_DLY = 4000;
  localparam int REVERB_DLY = 1200;
  localparam int ACK_TIMEOUT = 64;
  localparam int DEPTH = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        sel = 3'b010;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] past_sample;
  logic              past_valid;
  logic [DATA_W-1:0] mix_in = '0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              busy;
  logic              overrun;
  logic              timeout_err;

  team_06_delay_line_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ECHO_DLY(ECHO_DLY),
    .REVERB_DLY(REVERB_DLY), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .sample_valid(sample_valid),
    .past_sample(past_sample), .past_valid(past_valid), .mix_in(mix_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit we;
    int addr;
    int data;
  } txn_t;

  txn_t exp_txn[$];
  int   exp_past[$];
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] sram [DEPTH];
  int   wr_m = 0;
  int   fill_m = 0;
  logic [2:0] prev_m = 3'b000;

  int   ack_delay = 1;
  int   wait_cnt = 0;
  int   n_rd = 0, n_wr = 0, n_req = 0;
  int   last_rd = -1, last_wr = -1, prev_wr = -1, last_past = -1;
  int   last_pv_cyc = 0, idle_cyc = 0, req_len = 0, last_req_len = 0;
  logic req_q = 1'b0, ack_q = 1'b0, we_q = 1'b0;
  logic [ADDR_W-1:0] addr_q = '0;
  logic [DATA_W-1:0] wd_q = '0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    wr_m = 0;
    fill_m = 0;
    prev_m = 3'b000;
  endtask

  // Everything one accepted sample must produce: optional read, past value, write.
  task automatic model_accept(input logic [DATA_W-1:0] mix, input bit rd_timeout);
    int   d;
    int   ra;
    txn_t t;
    d = (sel == 3'b010) ? ECHO_DLY : REVERB_DLY;
    if (sel != prev_m) fill_m = 0;
    prev_m = sel;
    if (fill_m >= d) begin
      ra = (wr_m - d + DEPTH) % DEPTH;
      if (rd_timeout) begin
        exp_past.push_back(0);
      end else begin
        t.we = 1'b0; t.addr = ra; t.data = int'(ref_mem[ra]);
        exp_txn.push_back(t);
        exp_past.push_back(int'(ref_mem[ra]));
      end
    end else begin
      exp_past.push_back(0);
    end
    t.we = 1'b1; t.addr = wr_m; t.data = int'(mix);
    exp_txn.push_back(t);
    ref_mem[wr_m] = mix;
    wr_m = (wr_m + 1) % DEPTH;
    if (fill_m < DEPTH - 1) fill_m++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    if (busy) check("idle_wait_expired", int'(busy), 0);
    idle_cyc = cyc;
  endtask

  task automatic wait_wr_req();
    int n;
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin
      step();
      n++;
    end
    check("wr_req_seen", int'(mem_req && mem_we), 1);
  endtask

  task automatic run_sample(input logic [DATA_W-1:0] mix, input int dly);
    ack_delay = dly;
    mix_in = mix;
    sample_valid = 1'b1;
    if (sel == 3'b010 || sel == 3'b100) model_accept(mix, 1'b0);
    else fill_m = 0;
    step();
    sample_valid = 1'b0;
    wait_idle();
    step();
  endtask

  // SRAM R/W module stand-in: acks in the ack_delay-th cycle of each request.
  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack || !mem_req) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
        mem_rdata = DATA_W'($urandom);
      end else begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) sram[mem_addr] = mem_wdata;
          else mem_rdata = sram[mem_addr];
        end
      end
    end
  end

  // Compare process: protocol stability, completed transactions, past_valid values.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_q = 1'b0;
        ack_q = 1'b0;
        req_len = 0;
      end else begin
        if (mem_req && req_q && !ack_q)
          check("req_fields_hold", int'({mem_we, mem_addr, mem_wdata}), int'({we_q, addr_q, wd_q}));
        if (mem_req && !req_q) n_req++;
        if (mem_req) req_len++;
        else if (req_q) begin
          last_req_len = req_len;
          req_len = 0;
        end
        if (mem_req && mem_ack) begin
          if (exp_txn.size() == 0) begin
            check("unexpected_txn", 1, 0);
          end else begin
            e = exp_txn.pop_front();
            check("txn_we", int'(mem_we), int'(e.we));
            check("txn_addr", int'(mem_addr), e.addr);
            check("txn_data", e.we ? int'(mem_wdata) : int'(mem_rdata), e.data);
          end
          if (mem_we) begin
            prev_wr = last_wr;
            last_wr = int'(mem_addr);
            n_wr++;
          end else begin
            last_rd = int'(mem_addr);
            n_rd++;
          end
        end
        if (past_valid) begin
          if (exp_past.size() == 0) check("unexpected_past_valid", 1, 0);
          else check("past_sample", int'(past_sample), exp_past.pop_front());
          last_past = int'(past_sample);
          last_pv_cyc = cyc;
        end
        req_q = mem_req;
        ack_q = mem_ack;
        we_q = mem_we;
        addr_q = mem_addr;
        wd_q = mem_wdata;
      end
    end
  end

  initial begin
    int nr, nw, nq, w, acc;
    bit tmo_done;
    logic [DATA_W-1:0] m;
    logic [2:0] sel_tab [5];
    sel_tab[0] = 3'b000; sel_tab[1] = 3'b001; sel_tab[2] = 3'b010;
    sel_tab[3] = 3'b011; sel_tab[4] = 3'b100;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_past_valid", int'(past_valid), 0);
    check("rst_past_sample", int'(past_sample), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    step();
    rst = 1'b0;
    model_reset();

    // Reset in the middle of a write at wr_ptr=5
    for (int i = 0; i < 5; i++) run_sample(DATA_W'($urandom), 1);
    ack_delay = 1000;
    mix_in = 8'h5A;
    sample_valid = 1'b1;
    model_accept(8'h5A, 1'b0);
    step();
    sample_valid = 1'b0;
    wait_wr_req();
    check("pre_rst_wr_addr", int'(mem_addr), 5);
    #3 rst = 1'b1;
    #1;
    check("rst_async_req_drop", int'(mem_req), 0);
    check("rst_async_busy", int'(busy), 0);
    exp_txn.delete();
    exp_past.delete();
    model_reset();
    step();
    step();
    rst = 1'b0;
    ack_delay = 1;
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_flags", int'({overrun, timeout_err, past_valid}), 0);

    // Echo warm-up: 4000 writes without any read
    nr = n_rd;
    for (int i = 0; i < ECHO_DLY; i++) begin
      run_sample(DATA_W'(i), 1);
      if (i == 0) check("post_rst_wr_addr", last_wr, 0);
    end
    check("warmup_no_reads", n_rd - nr, 0);
    run_sample(DATA_W'(ECHO_DLY), 1);
    check("echo_first_rd_addr", last_rd, 0);
    check("echo_first_past", last_past, 8'h00);
    check("echo_first_wr_addr", last_wr, 4000);

    // Switch echo -> reverb while the echo write is outstanding
    ack_delay = 4;
    m = DATA_W'($urandom);
    mix_in = m;
    sample_valid = 1'b1;
    model_accept(m, 1'b0);
    step();
    sample_valid = 1'b0;
    wait_wr_req();
    sel = 3'b100;
    wait_idle();
    step();
    check("echo_wr_completes", last_wr, 4001);
    nr = n_rd;
    run_sample(DATA_W'($urandom), 1);
    check("switch_skips_read", n_rd - nr, 0);

    // Reverb run through the address wrap, with one read timeout on the way
    tmo_done = 1'b0;
    while (wr_m != 100) begin
      w = wr_m;
      if (!tmo_done && fill_m == 1300) begin
        tmo_done = 1'b1;
        ack_delay = 1000;
        m = DATA_W'($urandom);
        mix_in = m;
        sample_valid = 1'b1;
        model_accept(m, 1'b1);
        step();
        sample_valid = 1'b0;
        nq = 0;
        while (!timeout_err && nq < 200) begin
          step();
          nq++;
        end
        check("timeout_err_set", int'(timeout_err), 1);
        ack_delay = 1;
        @(negedge clk);
        check("timeout_req_len", last_req_len, ACK_TIMEOUT);
        wait_idle();
        step();
      end else begin
        run_sample(DATA_W'($urandom), $urandom_range(1, 3));
      end
      if (w == 0) begin
        check("wrap_prev_wr", prev_wr, DEPTH - 1);
        check("wrap_wr", last_wr, 0);
      end
    end
    ack_delay = 2;
    m = DATA_W'($urandom);
    mix_in = m;
    sample_valid = 1'b1;
    acc = cyc + 1;
    model_accept(m, 1'b0);
    step();
    sample_valid = 1'b0;
    wait_idle();
    step();
    check("reverb_wrap_rd_addr", last_rd, 7092);
    check("latency_past_valid", last_pv_cyc - acc, 2);
    check("latency_idle", idle_cyc - acc, 5);

    // Overrun: second strobe two cycles into a slow transaction
    nr = n_rd;
    nw = n_wr;
    ack_delay = 10;
    m = DATA_W'($urandom);
    mix_in = m;
    sample_valid = 1'b1;
    model_accept(m, 1'b0);
    step();
    sample_valid = 1'b0;
    step();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    wait_idle();
    step();
    check("overrun_set", int'(overrun), 1);
    check("overrun_one_read", n_rd - nr, 1);
    check("overrun_one_write", n_wr - nw, 1);
    check("timeout_err_sticky", int'(timeout_err), 1);
    sel = 3'b000;
    fill_m = 0;
    step();
    step();
    check("bypass_clears_overrun", int'(overrun), 0);
    check("bypass_clears_timeout", int'(timeout_err), 0);

    sel = 3'b011;
    nq = n_req;
    run_sample(DATA_W'($urandom), 1);
    check("bypass_no_req", n_req - nq, 0);

    // Random mode mix
    for (int i = 0; i < 60; i++) begin
      sel = sel_tab[$urandom_range(0, 4)];
      run_sample(DATA_W'($urandom), $urandom_range(1, 3));
    end

    check("exp_txn_drained", exp_txn.size(), 0);
    check("exp_past_drained", exp_past.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/team_06_delay_line_ctrl.md
Name: team_06_delay_line_ctrl

Overview:
Sequences the shared SRAM delay line used by the echo and reverb effects. On each new I2S sample it issues a read of the delayed sample, then a write of the mixed result. Both accesses go through the SRAM read/write module using a req/ack handshake. It owns the circular write pointer, the per-mode delay offset, warm-up gating, and error/overrun detection. It sits between the I2S "finished" strobe, the effect datapath, and the SRAM R/W module.

Parameters:
ADDR_W, 13, SRAM address width; the delay line is 2^ADDR_W bytes and wraps modulo 2^ADDR_W
DATA_W, 8, sample width
ECHO_DLY, 4000, delay in samples for sel=3'b010 (must be < 2^ADDR_W)
REVERB_DLY, 1200, delay in samples for sel=3'b100 (must be < 2^ADDR_W)
ACK_TIMEOUT, 64, cycles to wait for mem_ack before aborting

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sel  in  3  effect select from FSM; 010=echo, 100=reverb, others=bypass
sample_valid  in  1  one-cycle strobe: new sample available (I2S finished)
past_sample  out  DATA_W  delayed sample read from SRAM (0 during warm-up/error)
past_valid  out  1  one-cycle strobe: past_sample is valid
mix_in  in  DATA_W  effect datapath result to store; sampled the cycle after past_valid
mem_req  out  1  request to R/W module; held until mem_ack
mem_we  out  1  1=write (record), 0=read (search); stable while mem_req
mem_addr  out  ADDR_W  absolute SRAM address; stable while mem_req
mem_wdata  out  DATA_W  write data; stable while mem_req
mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle
mem_ack  in  1  one-cycle completion strobe from R/W module
busy  out  1  high in any state except IDLE
overrun  out  1  sticky: sample_valid arrived while busy; cleared by reset or on entering bypass
timeout_err  out  1  sticky: ack timeout occurred; cleared by reset or on entering bypass

Behaviour:
- Reset values: all outputs 0; wr_ptr=0; fill_cnt=0; state=IDLE.
- Active mode = sel is 010 or 100. Delay D = ECHO_DLY or REVERB_DLY. The mode and D are latched at sample_valid acceptance.
- Bypass mode: sample_valid is ignored, no mem_req is issued, wr_ptr is frozen, fill_cnt is cleared.
- When the latched mode differs from the previous accepted mode, fill_cnt is cleared at acceptance (the delay line is treated as empty).
- FSM states: IDLE, RD_REQ, MIX, WR_REQ.
  - IDLE: sample_valid in active mode moves to RD_REQ. If fill_cnt < D, the read is skipped: go straight to MIX with past_sample=0.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=(wr_ptr - D) mod 2^ADDR_W. On mem_ack, register mem_rdata into past_sample, pulse past_valid, then go to MIX.
  - MIX: a single cycle. Capture mix_in into the write-data register, then go to WR_REQ. (past_valid is asserted in the cycle entering MIX, so mix_in is sampled exactly 1 cycle after past_valid.)
  - WR_REQ: mem_req=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=captured mix. On mem_ack, wr_ptr increments (wraps 2^ADDR_W-1 -> 0), fill_cnt increments (saturates at 2^ADDR_W-1), and the FSM returns to IDLE.
- Skip path: past_valid still pulses, with past_sample=0.
- Minimum latency with zero-wait ack (ack in the cycle after req rises): sample_valid to past_valid = 2 cycles; sample to IDLE = 5 cycles.
- mem_req stays high continuously until ack. mem_addr, mem_we and mem_wdata are registered and never change while mem_req=1.
- A mem_ack received while mem_req=0 is ignored.
- Timeout: a counter resets on each req start. If it reaches ACK_TIMEOUT without ack:
  - drop mem_req, set timeout_err;
  - in RD_REQ: pulse past_valid with past_sample=0, continue to MIX;
  - in WR_REQ: return to IDLE, wr_ptr unchanged.
- Overrun: sample_valid while busy sets overrun; the sample is dropped and the current transaction is unaffected.
- sel change mid-transaction: the transaction completes with the latched mode; the new sel takes effect at the next sample_valid.
- Reset mid-transaction: immediate asynchronous return to IDLE, mem_req deasserted the same instant, SRAM contents are considered stale (fill_cnt=0).

Decomposition:
- Package team_06_audio_pkg: state enum dl_state_t {IDLE, RD_REQ, MIX, WR_REQ}; constants SEL_BYPASS=3'b000, SEL_TREMELO=3'b001, SEL_ECHO=3'b010, SEL_SOFTCLIP=3'b011, SEL_REVERB=3'b100.
- One natural sub-module: team_06_mem_handshake. It holds mem_req/addr/we/wdata registers plus the timeout counter and returns done/timed_out pulses to the FSM.

Test Plan:
- Reset mid WR_REQ (mem_req=1, wr_ptr=5) -> mem_req=0 immediately; after release wr_ptr=0, busy=0, all flags 0.
- Echo warm-up: sel=010, ack always 1 cycle after req; send 4000 samples with mix_in=sample index -> no read request is issued, past_sample=0 each time, writes go to addr 0..3999. On sample 4001: read addr 0, past_sample=0x00, and write addr 4000.
- Reverb wrap: sel=100, preload fill, set wr_ptr=100 -> read addr=(100-1200) mod 8192=7092. Write at 8191 is followed by a write at addr 0.
- Overrun: pulse sample_valid twice, 2 cycles apart, with ack delayed 10 cycles -> overrun=1, exactly one read and one write issued. Switching sel to 000 clears overrun.
- Timeout: withhold mem_ack in RD_REQ -> mem_req drops after 64 cycles, timeout_err=1, past_valid pulses with 0, then a write is issued normally.
- Bypass and mode switch: sel=011 with sample_valid -> no mem_req. Switching 010 -> 100 mid-WR_REQ completes the echo write, then the next sample has fill_cnt=0 and the read is skipped.
